// File: rtl/button_gesture_decoder.sv
// Button gesture decoder: turns debounced press/release pulses into
// short/long/double/repeat event pulses, then holds off further input for a
// lockout window. Presses arriving during lockout are tallied in a
// saturating drop counter.
//
// state            | meaning
// -----------------+-------------------------------------------------------
// S_IDLE           | waiting for a press
// S_PRESSED        | first press held, timing toward the long threshold
// S_LONG_HELD      | long press held, emitting repeat pulses
// S_WAIT_SECOND    | short release seen, window open for a second press
// S_SECOND_PRESSED | second press held, waiting for its release
// S_LOCKOUT        | gesture complete, input ignored until window elapses
module button_gesture_decoder #(
  parameter logic [23:0] LONG_CYCLES    = 24'd12_000_000,
  parameter logic [23:0] DOUBLE_WINDOW  = 24'd6_000_000,
  parameter logic [23:0] REPEAT_CYCLES  = 24'd3_000_000,
  parameter logic [23:0] LOCKOUT_CYCLES = 24'd12_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_press,
  input  logic       i_release,
  input  logic       i_clear_dropped,
  output logic       o_short_press,
  output logic       o_long_press,
  output logic       o_double_press,
  output logic       o_repeat,
  output logic       o_busy,
  output logic [7:0] o_dropped_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESSED,
    S_LONG_HELD,
    S_WAIT_SECOND,
    S_SECOND_PRESSED,
    S_LOCKOUT
  } state_t;

  state_t      r_state;
  logic [23:0] r_cnt;
  logic        r_short;
  logic        r_long;
  logic        r_double;
  logic        r_repeat;
  logic        r_busy;
  logic [7:0]  r_dropped;

  // A press coinciding with a release is discarded outright.
  logic w_press;
  logic w_long_tc;
  logic w_double_tc;
  logic w_repeat_tc;
  logic w_lockout_tc;

  assign w_press      = i_press & ~i_release;
  assign w_long_tc    = (r_cnt == LONG_CYCLES    - 24'd1);
  assign w_double_tc  = (r_cnt == DOUBLE_WINDOW  - 24'd1);
  assign w_repeat_tc  = (r_cnt == REPEAT_CYCLES  - 24'd1);
  assign w_lockout_tc = (r_cnt == LOCKOUT_CYCLES - 24'd1);

  // Gesture FSM with shared cycle counter and registered event pulses.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_repeat <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_repeat <= 1'b0;
      r_cnt    <= r_cnt + 24'd1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_press) begin
            r_state <= S_PRESSED;
            r_busy  <= 1'b1;
          end
        end
        S_PRESSED: begin
          // Release on the threshold edge still counts as a long press.
          if (w_long_tc) begin
            r_long  <= 1'b1;
            r_cnt   <= '0;
            r_state <= i_release ? S_LOCKOUT : S_LONG_HELD;
          end else if (i_release) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_SECOND;
          end
        end
        S_LONG_HELD: begin
          // Release on a repeat edge suppresses that repeat.
          if (i_release) begin
            r_cnt   <= '0;
            r_state <= S_LOCKOUT;
          end else if (w_repeat_tc) begin
            r_repeat <= 1'b1;
            r_cnt    <= '0;
          end
        end
        S_WAIT_SECOND: begin
          // A press on the final window edge beats expiry.
          if (w_press) begin
            r_cnt   <= '0;
            r_state <= S_SECOND_PRESSED;
          end else if (w_double_tc) begin
            r_short <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_LOCKOUT;
          end
        end
        S_SECOND_PRESSED: begin
          // No timeout here; the counter free-runs and is ignored.
          if (i_release) begin
            r_double <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_LOCKOUT;
          end
        end
        S_LOCKOUT: begin
          if (w_lockout_tc) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Saturating count of presses swallowed by lockout; clear has priority.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_dropped <= 8'd0;
    end else if (i_clear_dropped) begin
      r_dropped <= 8'd0;
    end else if ((r_state == S_LOCKOUT) && w_press && (r_dropped != 8'hFF)) begin
      r_dropped <= r_dropped + 8'd1;
    end
  end

  assign o_short_press   = r_short;
  assign o_long_press    = r_long;
  assign o_double_press  = r_double;
  assign o_repeat        = r_repeat;
  assign o_busy          = r_busy;
  assign o_dropped_count = r_dropped;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Bench for button_gesture_decoder: directed gesture scenarios followed by
// random press/release/clear traffic, all compared every cycle against a
// timestamp-based model of the gesture rules.
module tb_button_gesture_decoder;

  localparam int LONG = 8;
  localparam int DBL  = 4;
  localparam int REP  = 3;
  localparam int LOCK = 5;

  localparam int M_IDLE   = 0;
  localparam int M_PRESS  = 1;
  localparam int M_HELD   = 2;
  localparam int M_WAIT   = 3;
  localparam int M_SECOND = 4;
  localparam int M_LOCK   = 5;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_press = 1'b0;
  logic       i_release = 1'b0;
  logic       i_clear_dropped = 1'b0;
  logic       o_short_press;
  logic       o_long_press;
  logic       o_double_press;
  logic       o_repeat;
  logic       o_busy;
  logic [7:0] o_dropped_count;

  button_gesture_decoder #(
    .LONG_CYCLES   (24'd8),
    .DOUBLE_WINDOW (24'd4),
    .REPEAT_CYCLES (24'd3),
    .LOCKOUT_CYCLES(24'd5)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_press        (i_press),
    .i_release      (i_release),
    .i_clear_dropped(i_clear_dropped),
    .o_short_press  (o_short_press),
    .o_long_press   (o_long_press),
    .o_double_press (o_double_press),
    .o_repeat       (o_repeat),
    .o_busy         (o_busy),
    .o_dropped_count(o_dropped_count)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: current gesture phase and the edge at which it was entered
  int m_mode = M_IDLE;
  int m_t    = 0;
  int m_drop = 0;
  bit e_short, e_long, e_double, e_repeat;
  int edge_n = 0;

  // per-scenario tallies of observed DUT pulses
  int cnt_short, cnt_long, cnt_double, cnt_repeat;
  int edge_short, edge_long, edge_double, edge_busy_fall;
  bit prev_busy = 1'b0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic clear_tally();
    cnt_short = 0; cnt_long = 0; cnt_double = 0; cnt_repeat = 0;
    edge_short = -1; edge_long = -1; edge_double = -1; edge_busy_fall = -1;
  endtask

  task automatic model_step(input bit p_raw, input bit r, input bit c);
    bit p;
    int d;
    p = p_raw && !r;
    d = edge_n - m_t;
    e_short = 0; e_long = 0; e_double = 0; e_repeat = 0;
    if (c) m_drop = 0;
    else if (m_mode == M_LOCK && p && m_drop < 255) m_drop++;
    case (m_mode)
      M_IDLE: if (p) begin m_mode = M_PRESS; m_t = edge_n; end
      M_PRESS: begin
        if (d == LONG) begin
          e_long = 1;
          m_mode = r ? M_LOCK : M_HELD;
          m_t = edge_n;
        end else if (r) begin
          m_mode = M_WAIT; m_t = edge_n;
        end
      end
      M_HELD: begin
        if (r) begin m_mode = M_LOCK; m_t = edge_n; end
        else if (d > 0 && d % REP == 0) e_repeat = 1;
      end
      M_WAIT: begin
        if (p) begin m_mode = M_SECOND; m_t = edge_n; end
        else if (d == DBL) begin e_short = 1; m_mode = M_LOCK; m_t = edge_n; end
      end
      M_SECOND: if (r) begin e_double = 1; m_mode = M_LOCK; m_t = edge_n; end
      default: if (d == LOCK) begin m_mode = M_IDLE; m_t = edge_n; end
    endcase
  endtask

  task automatic cycle(input bit p, input bit r, input bit c);
    @(negedge i_clk);
    i_press = p; i_release = r; i_clear_dropped = c;
    @(posedge i_clk);
    edge_n++;
    model_step(p, r, c);
    #1;
    check_val("short_press",  int'(o_short_press),  int'(e_short));
    check_val("long_press",   int'(o_long_press),   int'(e_long));
    check_val("double_press", int'(o_double_press), int'(e_double));
    check_val("repeat",       int'(o_repeat),       int'(e_repeat));
    check_val("busy",         int'(o_busy),         int'(m_mode != M_IDLE));
    check_val("dropped_count", int'(o_dropped_count), m_drop);
    check_val("one_event", int'($countones({o_short_press, o_long_press,
                                             o_double_press, o_repeat}) <= 1), 1);
    if (o_short_press)  begin cnt_short++;  edge_short  = edge_n; end
    if (o_long_press)   begin cnt_long++;   edge_long   = edge_n; end
    if (o_double_press) begin cnt_double++; edge_double = edge_n; end
    if (o_repeat)       cnt_repeat++;
    if (prev_busy && !o_busy) edge_busy_fall = edge_n;
    prev_busy = o_busy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  // asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    @(negedge i_clk);
    i_press = 0; i_release = 0; i_clear_dropped = 0;
    #2 i_reset = 1'b0;
    #1;
    check_val("rst_short",   int'(o_short_press),   0);
    check_val("rst_long",    int'(o_long_press),    0);
    check_val("rst_double",  int'(o_double_press),  0);
    check_val("rst_repeat",  int'(o_repeat),        0);
    check_val("rst_busy",    int'(o_busy),          0);
    check_val("rst_dropped", int'(o_dropped_count), 0);
    m_mode = M_IDLE; m_t = edge_n; m_drop = 0;
    prev_busy = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b1;
  endtask

  initial begin
    int k;
    bit p, r, c;

    // initial reset and reset-state check
    #12;
    check_val("init_busy",    int'(o_busy), 0);
    check_val("init_dropped", int'(o_dropped_count), 0);
    check_val("init_events",  int'({o_short_press, o_long_press, o_double_press, o_repeat}), 0);
    @(negedge i_clk);
    i_reset = 1'b1;
    idle(3);

    // short press: press k, release k+3 -> short at k+7, idle at k+12
    clear_tally();
    k = edge_n + 1;
    cycle(1, 0, 0); idle(2); cycle(0, 1, 0); idle(14);
    check_val("s1_short_cnt",  cnt_short, 1);
    check_val("s1_short_edge", edge_short - k, 7);
    check_val("s1_busy_fall",  edge_busy_fall - k, 12);
    check_val("s1_other", cnt_long + cnt_double + cnt_repeat, 0);

    // double press: press k, release k+2, press k+4, release k+10
    clear_tally();
    k = edge_n + 1;
    cycle(1, 0, 0); idle(1); cycle(0, 1, 0); idle(1); cycle(1, 0, 0);
    idle(5); cycle(0, 1, 0); idle(8);
    check_val("s2_double_cnt",  cnt_double, 1);
    check_val("s2_double_edge", edge_double - k, 10);
    check_val("s2_short_cnt",   cnt_short, 0);
    check_val("s2_dropped",     int'(o_dropped_count), 0);

    // long hold: press k, release k+17 -> long k+8, repeats k+11,k+14 only
    clear_tally();
    k = edge_n + 1;
    cycle(1, 0, 0); idle(16); cycle(0, 1, 0); idle(8);
    check_val("s3_long_edge", edge_long - k, 8);
    check_val("s3_repeats",   cnt_repeat, 2);
    check_val("s3_busy_fall", edge_busy_fall - k, 22);

    // release exactly on the long threshold
    clear_tally();
    k = edge_n + 1;
    cycle(1, 0, 0); idle(7); cycle(0, 1, 0); idle(8);
    check_val("s4_long_cnt",  cnt_long, 1);
    check_val("s4_repeats",   cnt_repeat, 0);
    check_val("s4_busy_fall", edge_busy_fall - k, 13);

    // saturation: 60 gestures x 5 lockout presses = 300 drops
    for (int g = 0; g < 60; g++) begin
      cycle(1, 0, 0); cycle(0, 1, 0); idle(4);
      for (int j = 0; j < 5; j++) cycle(1, 0, 0);
    end
    check_val("sat_dropped", int'(o_dropped_count), 255);
    idle(3);

    // reset mid-press aborts the gesture; the later release yields nothing
    clear_tally();
    cycle(1, 0, 0); idle(5);
    do_reset();
    cycle(0, 1, 0); idle(12);
    check_val("rst_no_events", cnt_short + cnt_long + cnt_double + cnt_repeat, 0);

    // clear coinciding with a drop wins
    cycle(1, 0, 0); cycle(0, 1, 0); idle(4);
    cycle(1, 0, 0); cycle(1, 0, 0);
    check_val("pre_clear", int'(o_dropped_count), 2);
    cycle(1, 0, 1);
    check_val("clear_wins", int'(o_dropped_count), 0);
    idle(6);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      p = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle(p, r, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
